// File: rtl/pipe_flow_ctrl.sv
// Valid/ready flow controller for a DEPTH-stage datapath: per-stage load enables,
// per-stage valid tracking with bubble collapse, synchronous flush and transfer counters.
module pipe_flow_ctrl #(
  parameter int DEPTH = 3,
  parameter int CW    = 8,
  localparam int OW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             flush,
  output logic [DEPTH-1:0] stage_en,
  output logic [DEPTH-1:0] stage_valid,
  output logic [OW-1:0]    occupancy,
  output logic             empty,
  output logic [CW-1:0]    accept_cnt,
  output logic [CW-1:0]    retire_cnt
);

  logic [DEPTH-1:0] r_valid;
  logic [CW-1:0]    r_acceptCnt;
  logic [CW-1:0]    r_retireCnt;

  logic [DEPTH-1:0] w_chainEn;
  logic             w_active;
  logic             w_inXfer;
  logic             w_outXfer;
  logic [OW-1:0]    w_occ;

  // A stage may load when it is empty or its successor is loading, so holes
  // upstream of a stalled stage still fill (bubble collapse).
  always_comb begin
    w_chainEn = '0;
    w_chainEn[DEPTH-1] = ~r_valid[DEPTH-1] | out_ready;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      w_chainEn[i] = ~r_valid[i] | w_chainEn[i+1];
    end
  end

  assign w_active  = ~rst & ~flush;
  assign stage_en  = w_active ? w_chainEn : '0;
  assign in_ready  = w_active & w_chainEn[0];
  assign out_valid = w_active & r_valid[DEPTH-1];
  assign w_inXfer  = in_valid & in_ready;
  assign w_outXfer = out_valid & out_ready;

  always_comb begin
    w_occ = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_occ = w_occ + OW'(r_valid[i]);
    end
  end

  assign stage_valid = r_valid;
  assign occupancy   = rst ? '0 : w_occ;
  assign empty       = rst | (r_valid == '0);
  assign accept_cnt  = r_acceptCnt;
  assign retire_cnt  = r_retireCnt;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_valid <= '0;
    end else begin
      if (w_chainEn[0]) r_valid[0] <= w_inXfer;
      for (int i = 1; i < DEPTH; i++) begin
        if (w_chainEn[i]) r_valid[i] <= r_valid[i-1];
      end
    end
  end

  // Transfers are already suppressed during flush, so counters simply hold then.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acceptCnt <= '0;
      r_retireCnt <= '0;
    end else begin
      r_acceptCnt <= r_acceptCnt + CW'(w_inXfer);
      r_retireCnt <= r_retireCnt + CW'(w_outXfer);
    end
  end

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Self-checking bench for pipe_flow_ctrl: slot-array reference model plus a
// small bench-side datapath (F = A*B+C-D) clocked by stage_en to check ordering and stalls.
module tb_pipe_flow_ctrl;

  localparam int DEPTH = 3;
  localparam int CW    = 4;
  localparam int OW    = $clog2(DEPTH + 1);
  localparam int CMASK = (1 << CW) - 1;

  logic             clk = 1'b0;
  logic             rst, in_valid, out_ready, flush;
  logic             in_ready, out_valid, empty;
  logic [DEPTH-1:0] stage_en, stage_valid;
  logic [OW-1:0]    occupancy;
  logic [CW-1:0]    accept_cnt, retire_cnt;

  logic [15:0] opA, opB, opC, opD;
  logic [15:0] pipeReg [DEPTH] = '{default: 16'h0};
  logic [15:0] fOut;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: one slot per stage holding valid + expected F.
  bit          mValid [DEPTH];
  logic [15:0] mF     [DEPTH];
  int          mAcc, mRet;

  // Snapshot of DUT outputs taken mid-cycle, for the directed literal checks.
  logic             sIn, sOut, sEmpty;
  logic [DEPTH-1:0] sEn, sSv;
  logic [OW-1:0]    sOcc;
  logic [CW-1:0]    sAcc, sRet;
  logic [15:0]      sF;

  always #5 clk = ~clk;

  pipe_flow_ctrl #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .flush(flush),
    .stage_en(stage_en), .stage_valid(stage_valid), .occupancy(occupancy),
    .empty(empty), .accept_cnt(accept_cnt), .retire_cnt(retire_cnt)
  );

  // Bench-side datapath: each bank loads only on its stage enable.
  always @(posedge clk) begin
    if (stage_en[0]) pipeReg[0] <= opA * opB + opC - opD;
    for (int i = 1; i < DEPTH; i++) begin
      if (stage_en[i]) pipeReg[i] <= pipeReg[i-1];
    end
  end
  assign fOut = pipeReg[DEPTH-1];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare all outputs against the model at
  // the falling edge, then advance the model across the rising edge.
  task automatic applyStimulus(input logic iv, input logic ordy, input logic fl, input logic rs,
                               input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] c, input logic [15:0] d);
    int h, cnt, top;
    bit active, full, expIn, expOut, inX, outX;
    logic [DEPTH-1:0] expEn, mv;
    in_valid = iv; out_ready = ordy; flush = fl; rst = rs;
    opA = a; opB = b; opC = c; opD = d;
    @(negedge clk);
    cyc++;
    h = -1; cnt = 0;
    for (int i = 0; i < DEPTH; i++) begin
      mv[i] = mValid[i];
      if (mValid[i]) cnt++;
      else h = i;
    end
    full   = (h < 0);
    active = !rs && !fl;
    expIn  = active && (!full || ordy);
    expOut = active && mValid[DEPTH-1];
    if (!active)     expEn = '0;
    else if (ordy)   expEn = '1;
    else if (full)   expEn = '0;
    else             expEn = DEPTH'((1 << (h + 1)) - 1);
    checkOutput("in_ready",  32'(in_ready),  32'(expIn));
    checkOutput("out_valid", 32'(out_valid), 32'(expOut));
    checkOutput("stage_en",  32'(stage_en),  32'(expEn));
    checkOutput("occupancy", 32'(occupancy), rs ? 32'd0 : 32'(cnt));
    checkOutput("empty",     32'(empty),     32'(rs || cnt == 0));
    if (!rs) begin
      checkOutput("stage_valid", 32'(stage_valid), 32'(mv));
      checkOutput("accept_cnt",  32'(accept_cnt),  32'(mAcc & CMASK));
      checkOutput("retire_cnt",  32'(retire_cnt),  32'(mRet & CMASK));
    end
    if (expOut) checkOutput("F", 32'(fOut), 32'(mF[DEPTH-1]));
    sIn = in_ready; sOut = out_valid; sEmpty = empty; sEn = stage_en; sSv = stage_valid;
    sOcc = occupancy; sAcc = accept_cnt; sRet = retire_cnt; sF = fOut;
    @(posedge clk);
    inX  = expIn && iv;
    outX = expOut && ordy;
    if (rs) begin
      for (int i = 0; i < DEPTH; i++) mValid[i] = 1'b0;
      mAcc = 0; mRet = 0;
    end else if (fl) begin
      for (int i = 0; i < DEPTH; i++) mValid[i] = 1'b0;
    end else begin
      // Everything below the departing head (or below the topmost hole) moves up one slot.
      top = outX ? DEPTH - 1 : h;
      if (top >= 0) begin
        for (int i = top; i > 0; i--) begin
          mValid[i] = mValid[i-1];
          mF[i]     = mF[i-1];
        end
        mValid[0] = inX;
        mF[0]     = a * b + c - d;
      end
      mAcc += int'(inX);
      mRet += int'(outX);
    end
    #1;
  endtask

  task automatic idle(input logic ordy);
    applyStimulus(1'b0, ordy, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0);
  endtask

  task automatic feed(input logic ordy, input int k);
    applyStimulus(1'b1, ordy, 1'b0, 1'b0, 16'(k), 16'(2*k-1), 16'(2*k), 16'(k));
  endtask

  initial begin
    int firstAcc, firstOut, outs, peak;
    logic [15:0] fHold;
    logic [CW-1:0] base;
    logic [2:0] bubSv [6];
    bit bubIv [6];
    bit bubRdy [6];

    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0; flush = 1'b0;
    opA = 0; opB = 0; opC = 0; opD = 0;
    mAcc = 0; mRet = 0;
    for (int i = 0; i < DEPTH; i++) begin mValid[i] = 1'b0; mF[i] = 16'h0; end
    @(posedge clk); #1;

    // Reset held two cycles with in_valid high.
    for (int r = 0; r < 2; r++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 16'd7, 16'd7, 16'd7, 16'd7);
      checkOutput("rst_in_ready", 32'(sIn), 32'd0);
      checkOutput("rst_out_valid", 32'(sOut), 32'd0);
      checkOutput("rst_empty", 32'(sEmpty), 32'd1);
      checkOutput("rst_stage_en", 32'(sEn), 32'd0);
    end
    checkOutput("rst_accept_cnt", 32'(sAcc), 32'd0);
    checkOutput("rst_retire_cnt", 32'(sRet), 32'd0);
    idle(1'b1);
    checkOutput("post_rst_in_ready", 32'(sIn), 32'd1);

    // Streaming: 11 sets, one per cycle, then drain.
    firstAcc = -1; firstOut = -1; outs = 0; peak = 0;
    for (int k = 1; k <= 17; k++) begin
      if (k <= 11) feed(1'b1, k);
      else         idle(1'b1);
      if (sIn && k <= 11 && firstAcc < 0) firstAcc = cyc;
      if (sOut) begin
        if (firstOut < 0) firstOut = cyc;
        outs++;
      end
      if (int'(sOcc) > peak) peak = int'(sOcc);
    end
    checkOutput("stream_latency", 32'(firstOut - firstAcc), 32'd3);
    checkOutput("stream_results", 32'(outs), 32'd11);
    checkOutput("stream_accept_cnt", 32'(sAcc), 32'd11);
    checkOutput("stream_retire_cnt", 32'(sRet), 32'd11);
    checkOutput("stream_peak_occ", 32'(peak), 32'd3);

    // Backpressure: fill three stages, stall for four cycles, then drain.
    for (int k = 0; k < 3; k++) feed(1'b0, 20 + k);
    for (int k = 0; k < 4; k++) begin
      feed(1'b0, 30 + k);
      if (k == 0) fHold = sF;
      checkOutput("bp_in_ready", 32'(sIn), 32'd0);
      checkOutput("bp_stage_en", 32'(sEn), 32'd0);
      checkOutput("bp_out_valid", 32'(sOut), 32'd1);
      checkOutput("bp_F_stable", 32'(sF), 32'(fHold));
    end
    base = sRet;
    for (int k = 0; k < 4; k++) begin
      idle(1'b1);
      checkOutput("bp_retire_step", 32'(sRet), 32'((base + CW'(k)) & CW'(CMASK)));
    end
    checkOutput("bp_drained", 32'(sOut), 32'd0);

    // Bubble collapse with out_ready low.
    bubSv  = '{3'b000, 3'b001, 3'b010, 3'b101, 3'b110, 3'b111};
    bubIv  = '{1, 0, 1, 0, 1, 1};
    bubRdy = '{1, 1, 1, 1, 1, 0};
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'(bubIv[k]), 1'b0, 1'b0, 1'b0, 16'(40 + k), 16'd3, 16'd5, 16'd1);
      checkOutput("bubble_stage_valid", 32'(sSv), 32'(bubSv[k]));
      checkOutput("bubble_in_ready", 32'(sIn), 32'(bubRdy[k]));
    end

    // Flush mid-stream with all stages valid.
    base = sAcc;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'd9, 16'd9, 16'd9, 16'd9);
    checkOutput("flush_in_ready", 32'(sIn), 32'd0);
    checkOutput("flush_out_valid", 32'(sOut), 32'd0);
    feed(1'b1, 50);
    checkOutput("flush_stage_valid", 32'(sSv), 32'd0);
    checkOutput("flush_empty", 32'(sEmpty), 32'd1);
    checkOutput("flush_acc_hold", 32'(sAcc), 32'(base));
    checkOutput("flush_accept_next", 32'(sIn), 32'd1);
    idle(1'b1);
    checkOutput("flush_refill", 32'(sSv), 32'b001);

    // Randomised traffic with occasional flush and reset.
    for (int k = 0; k < 800; k++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                    1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 99) == 0),
                    16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    end

    // Counter wrap at CW = 4: 17 transfers each way leaves both at 1.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 16'd0, 16'd0, 16'd0, 16'd0);
    for (int k = 1; k <= 23; k++) begin
      if (k <= 17) feed(1'b1, k);
      else         idle(1'b1);
    end
    checkOutput("wrap_accept_cnt", 32'(sAcc), 32'd1);
    checkOutput("wrap_retire_cnt", 32'(sRet), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_flow_ctrl.md
Name: pipe_flow_ctrl

Overview:
- Valid/ready flow controller for the N-bit multi-stage arithmetic pipeline (inputs A, B, C, D; output F).
- Generates one register-load enable per pipeline stage and tracks which stages hold live data.
- Stalls upstream when downstream backpressures, collapses bubbles, and supports a synchronous flush.
- Sits between the producer of operand sets and the consumer of F; the datapath registers load only on their stage enable.

Parameters:
- DEPTH, 3, number of register stages in the controlled datapath (>=1).
- CW, 8, width of the accept/retire counters.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  producer presents an operand set (A, B, C, D)
- in_ready  output  1  controller accepts the operand set this cycle
- out_valid  output  1  last stage holds a valid F
- out_ready  input  1  consumer takes F this cycle
- flush  input  1  synchronous flush, discards all in-flight data
- stage_en  output  DEPTH  load enable for datapath register bank i (bit 0 = first stage)
- stage_valid  output  DEPTH  valid bit per stage
- occupancy  output  $clog2(DEPTH+1)  number of set stage_valid bits
- empty  output  1  stage_valid == 0
- accept_cnt  output  CW  count of accepted operand sets
- retire_cnt  output  CW  count of delivered results

Behaviour:
- One clock (clk); reset is synchronous, active-high (rst). No asynchronous state.
- Reset values:
  - stage_valid = 0, accept_cnt = 0, retire_cnt = 0.
  - While rst = 1: in_ready = 0, out_valid = 0, stage_en = 0, occupancy = 0, empty = 1.
- Enables (combinational, when rst = 0 and flush = 0):
  - en[DEPTH-1] = !v[DEPTH-1] | out_ready
  - en[i] = !v[i] | en[i+1] for i < DEPTH-1
  - stage_en = en
  - in_ready = en[0]
  - out_valid = v[DEPTH-1]
- Valid update at each edge:
  - If en[0]: v[0] <= in_valid & in_ready.
  - If en[i], i > 0: v[i] <= v[i-1].
  - Otherwise v[i] holds.
- Bubble collapse: an invalid stage loads even when a later stage is stalled.
- Latency: an operand set accepted at edge k appears with out_valid = 1 after edge k+DEPTH-1, i.e. DEPTH cycles after acceptance, provided there is no stall.
- Throughput: one result per cycle with out_ready held at 1.
- Backpressure:
  - With out_ready = 0 and all stages valid: stage_en = 0 and in_ready = 0.
  - The datapath holds; F stays stable while out_valid = 1 and out_ready = 0.
- Handshake rules:
  - Transfer in when in_valid & in_ready; transfer out when out_valid & out_ready.
  - in_valid may deassert freely.
  - out_valid, once high, stays high until taken, except on flush or reset.
- Counters:
  - accept_cnt increments on each input transfer; retire_cnt increments on each output transfer.
  - Both wrap modulo 2^CW. Simultaneous in and out transfers increment both in the same cycle.
- Flush (flush = 1, rst = 0):
  - That cycle: in_ready = 0, out_valid = 0, stage_en = 0; no transfers and no counter increments.
  - Next edge: stage_valid <= 0. Counters hold.
  - Back-to-back flush keeps the pipe empty.
- Priority: rst > flush > normal operation.
- Reset mid-stream: all in-flight data is dropped and counters return to 0 at the edge.
- Occupancy: occupancy = popcount(stage_valid); in steady state accept_cnt - retire_cnt (mod 2^CW) equals occupancy until a flush occurs.

Test Plan:
- Reset: hold rst for 2 cycles with in_valid = 1 -> in_ready = 0, out_valid = 0, counters 0, empty = 1. Release rst -> in_ready = 1 on the first cycle.
- Streaming (DEPTH = 3, out_ready = 1): feed A=1..11, B=2A-1, C=2A, D=A, one set per cycle.
  - Required: first out_valid exactly 3 cycles after first acceptance.
  - Required: 11 consecutive out_valid cycles in order; accept_cnt = retire_cnt = 11 at end; occupancy peaks at 3.
- Backpressure: fill 3 stages, drop out_ready for 4 cycles.
  - Required: in_ready = 0, stage_en = 000, F stable.
  - Raise out_ready -> one result per cycle resumes; no loss or duplication (retire_cnt increments exactly once per result).
- Bubble collapse: accept set 1, idle 1 cycle, accept set 2, hold out_ready = 0.
  - Required: stage_valid goes 001, 010, 101, then 110 then 111 while in_valid = 1; in_ready stays 1 until all three stages are valid.
- Flush mid-stream: with stage_valid = 111, assert flush for 1 cycle.
  - Required: that cycle in_ready = 0, out_valid = 0, no counter change.
  - Next cycle: stage_valid = 000, empty = 1; new input is accepted the following cycle.
- Counter wrap (CW = 4): stream 17 sets -> accept_cnt = retire_cnt = 1 after drain.
  - Simultaneous in/out cycles increment both counters once.
